// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencing - load-use stall, branch flush,
// memory-busy freeze with replay of a branch flush that arrives while frozen.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic             memwb_write,
    output logic             frozen,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    typedef enum logic {RUN = 1'b0, FREEZE = 1'b1} state_t;
    state_t           r_state, w_state_nxt;
    logic             r_pending, w_pending_nxt;
    logic             w_luh, w_stall_inc, w_flush_inc;
    logic [CNT_W-1:0] r_stall, r_flush;
    assign w_luh = idex_mem_read & (idex_rt != 5'd0) &
                   ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));
    always_comb begin
        pc_write      = 1'b0;
        ifid_write    = 1'b0;
        ifid_flush    = 1'b0;
        idex_write    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_write   = 1'b0;
        exmem_flush   = 1'b0;
        memwb_write   = 1'b0;
        w_state_nxt   = RUN;
        w_pending_nxt = r_pending;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;
        if (reset) begin
            w_pending_nxt = 1'b0;
        end else if (mem_busy) begin
            w_state_nxt   = FREEZE;
            w_pending_nxt = r_pending | branch_taken;
        end else if (branch_taken | r_pending) begin
            // squash IF/ID, ID/EX and EX/MEM in one cycle; any luh dies with them
            {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = '1;
            {ifid_flush, idex_bubble, exmem_flush} = '1;
            w_pending_nxt = 1'b0;
            w_flush_inc   = 1'b1;
        end else if (w_luh) begin
            {idex_write, idex_bubble, exmem_write, memwb_write} = '1;
            w_stall_inc = 1'b1;
        end else begin
            {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = '1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_pending <= 1'b0;
            r_stall   <= '0;
            r_flush   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_stall   <= (w_stall_inc && !(&r_stall)) ? r_stall + CNT_W'(1) : r_stall;
            r_flush   <= (w_flush_inc && !(&r_flush)) ? r_flush + CNT_W'(1) : r_flush;
        end
    end
    assign frozen       = (r_state == FREEZE);
    assign stall_cycles = r_stall;
    assign flush_events = r_flush;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus hand sequences for freeze,
// flush replay, reset-in-freeze and counter saturation.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, idex_mem_read, ifid_uses_rt, branch_taken, mem_busy;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;

    logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_write, a_idex_bubble;
    logic        a_exmem_write, a_exmem_flush, a_memwb_write, a_frozen;
    logic [15:0] a_stall, a_flush;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_bubble;
    logic        s_exmem_write, s_exmem_flush, s_memwb_write, s_frozen;
    logic [1:0]  s_stall, s_flush;
    logic [7:0]  a_ctl;

    assign a_ctl = {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_write,
                    a_idex_bubble, a_exmem_write, a_exmem_flush, a_memwb_write};

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
        .idex_write(a_idex_write), .idex_bubble(a_idex_bubble),
        .exmem_write(a_exmem_write), .exmem_flush(a_exmem_flush),
        .memwb_write(a_memwb_write), .frozen(a_frozen),
        .stall_cycles(a_stall), .flush_events(a_flush)
    );

    pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_write(s_idex_write), .idex_bubble(s_idex_bubble),
        .exmem_write(s_exmem_write), .exmem_flush(s_exmem_flush),
        .memwb_write(s_memwb_write), .frozen(s_frozen),
        .stall_cycles(s_stall), .flush_events(s_flush)
    );

    localparam logic [7:0] C_ZERO = 8'h00;
    localparam logic [7:0] C_NORM = 8'hD5;
    localparam logic [7:0] C_FLSH = 8'hFF;
    localparam logic [7:0] C_LUH  = 8'h1D;

    typedef struct {
        logic       rst, busy, br, mr;
        logic [4:0] irt, rs, rt;
        logic       urt;
        logic [7:0] ctl;
        logic       frz;
        int         st, fl;
    } vec_t;

    vec_t tv[17];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic rst, logic busy, logic br, logic mr, logic [4:0] irt,
                                logic [4:0] rs, logic [4:0] rt, logic urt, logic [7:0] ctl,
                                logic frz, int st, int fl);
        vec_t v;
        v.rst = rst; v.busy = busy; v.br = br; v.mr = mr;
        v.irt = irt; v.rs = rs; v.rt = rt; v.urt = urt;
        v.ctl = ctl; v.frz = frz; v.st = st; v.fl = fl;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic busy, input logic br, input logic mr,
                         input logic [4:0] irt, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt);
        @(negedge clk);
        reset = rst; mem_busy = busy; branch_taken = br; idex_mem_read = mr;
        idex_rt = irt; ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = urt;
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        tv[0]  = mk(1, 1, 1, 0, 0, 0, 0, 0, C_ZERO, 0, 0, 0);
        tv[1]  = mk(1, 1, 1, 0, 0, 0, 0, 0, C_ZERO, 0, 0, 0);
        tv[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0, 0);
        tv[3]  = mk(0, 0, 0, 1, 8, 8, 0, 0, C_LUH,  0, 0, 0);
        tv[4]  = mk(0, 0, 0, 0, 8, 8, 0, 0, C_NORM, 0, 1, 0);
        tv[5]  = mk(0, 0, 0, 1, 0, 0, 0, 1, C_NORM, 0, 1, 0);
        tv[6]  = mk(0, 0, 0, 1, 9, 3, 9, 1, C_LUH,  0, 1, 0);
        tv[7]  = mk(0, 0, 0, 1, 9, 3, 9, 0, C_NORM, 0, 2, 0);
        tv[8]  = mk(0, 0, 1, 1, 8, 8, 0, 0, C_FLSH, 0, 2, 0);
        tv[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 2, 1);
        tv[10] = mk(0, 0, 0, 0, 5, 5, 0, 0, C_NORM, 0, 2, 1);
        tv[11] = mk(0, 1, 0, 1, 8, 8, 0, 0, C_ZERO, 0, 2, 1);
        tv[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, C_ZERO, 1, 2, 1);
        tv[13] = mk(0, 0, 0, 1, 8, 8, 0, 0, C_LUH,  1, 2, 1);
        tv[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 3, 1);
        tv[15] = mk(1, 0, 0, 1, 8, 8, 0, 0, C_ZERO, 0, 3, 1);
        tv[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0, 0);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            drive(tv[i].rst, tv[i].busy, tv[i].br, tv[i].mr, tv[i].irt, tv[i].rs,
                  tv[i].rt, tv[i].urt);
            #1;
            chk("ctl", i, 16'(a_ctl), 16'(tv[i].ctl));
            chk("frozen", i, 16'(a_frozen), 16'(tv[i].frz));
            chk("stall", i, a_stall, 16'(tv[i].st));
            chk("flush", i, a_flush, 16'(tv[i].fl));
        end

        // four-cycle freeze, branch only in the second cycle, replayed on release
        for (int c = 0; c < 4; c++) begin
            drive(0, 1, c == 1, 0, 0, 0, 0, 0);
            #1;
            chk("frz_ctl", c, 16'(a_ctl), 16'(C_ZERO));
            chk("frz_frozen", c, 16'(a_frozen), 16'(c != 0));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("replay_ctl", 0, 16'(a_ctl), 16'(C_FLSH));
        chk("replay_frozen", 0, 16'(a_frozen), 16'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post_ctl", 0, 16'(a_ctl), 16'(C_NORM));
        chk("post_frozen", 0, 16'(a_frozen), 16'd0);
        chk("post_flush", 0, a_flush, 16'd1);

        // branch held across the whole freeze counts once
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 1, 0, 0, 0, 0, 0);
            #1;
            chk("hold_ctl", c, 16'(a_ctl), 16'(C_ZERO));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("hold_rel_ctl", 0, 16'(a_ctl), 16'(C_FLSH));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("hold_post_ctl", 0, 16'(a_ctl), 16'(C_NORM));
        chk("hold_flush", 0, a_flush, 16'd2);

        // reset during freeze discards the pending flush
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        #1;
        chk("rf_busy_ctl", 0, 16'(a_ctl), 16'(C_ZERO));
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rf_rst_ctl", 0, 16'(a_ctl), 16'(C_ZERO));
        chk("rf_rst_frozen", 0, 16'(a_frozen), 16'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rf_idle_ctl", 0, 16'(a_ctl), 16'(C_NORM));
        chk("rf_idle_frozen", 0, 16'(a_frozen), 16'd0);
        chk("rf_idle_flush", 0, a_flush, 16'd0);

        // five separate stalls: 2-bit counter saturates at 3, 16-bit keeps counting
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1, 8, 8, 0, 0);
            #1;
            chk("sat_luh_ctl", k, 16'(a_ctl), 16'(C_LUH));
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("sat_stall", k, 16'(s_stall), 16'((k + 1 > 3) ? 3 : k + 1));
            chk("wide_stall", k, a_stall, 16'(k + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
